// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the single-precision adder sequencer.
//   - state_t    : sequencer states
//   - op_class_t : operand-pair classification produced by dec_operanzi
//   - field widths and special encodings of IEEE-754 single precision
package fp_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MANT_W  = 23;
    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,  // both operands finite and non-zero
        CLS_NAN    = 2'd1,  // NaN input or inf + (-inf)
        CLS_INF    = 2'd2,  // at least one infinity, result is that infinity
        CLS_ZERO   = 2'd3   // at least one zero (denormals count as zero)
    } op_class_t;

endpackage

// File: rtl/dec_operanzi.sv
// dec_operanzi: combinational operand decoder.
//   a, b      : captured IEEE-754 single operands
//   swap      : 1 when b has the strictly larger exponent (b becomes X)
//   exp_max   : larger of the two exponents
//   exp_diff  : |ea - eb|
//   op_class  : special-case classification of the pair
module dec_operanzi
    import fp_pkg::*;
(
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             swap,
    output logic [EXP_W-1:0] exp_max,
    output logic [EXP_W-1:0] exp_diff,
    output op_class_t        op_class
);

    logic [EXP_W-1:0]  ea, eb;
    logic [MANT_W-1:0] ma, mb;
    logic              sa, sb;

    assign sa = a[31];
    assign sb = b[31];
    assign ea = a[30:23];
    assign eb = b[30:23];
    assign ma = a[22:0];
    assign mb = b[22:0];

    // On an exponent tie a stays X, so swap only on strict greater-than.
    assign swap     = (eb > ea);
    assign exp_max  = swap ? eb : ea;
    assign exp_diff = swap ? (eb - ea) : (ea - eb);

    always_comb begin
        op_class = CLS_NORMAL;
        if (ea == EXP_INF || eb == EXP_INF) begin
            if ((ea == EXP_INF && ma != '0) ||
                (eb == EXP_INF && mb != '0) ||
                (ea == EXP_INF && eb == EXP_INF && sa != sb))
                op_class = CLS_NAN;
            else
                op_class = CLS_INF;
        end else if (ea == '0 || eb == '0) begin
            op_class = CLS_ZERO;
        end
    end

endmodule

// File: rtl/ctrl_adunare.sv
// ctrl_adunare: multi-cycle sequencer for the single-precision adder.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake, a/b captured when both high
//   a, b                 : IEEE-754 single operands
//   out_valid/out_ready  : result handshake, result/flags held while
//                          out_valid is high and out_ready is low
//   result               : packed sum (truncating)
//   ovf, unf, nan        : overflow-to-inf, underflow-to-zero, NaN flags
//   dbg_state            : current sequencer state (fp_pkg::state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; a
// producer may hold valid high across any number of non-ready cycles.
module ctrl_adunare
    import fp_pkg::*;
#(
    parameter int MAX_SHIFT = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        nan,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    state_t            state;
    logic [31:0]       ra, rb;
    logic [CNT_W-1:0]  cnt;
    logic [MANT_W:0]   mx, my;
    logic              sx, sy;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W+1:0] sum;
    logic              sgn;

    logic              swap;
    logic [EXP_W-1:0]  exp_max, exp_diff;
    op_class_t         op_class;

    logic [CNT_W-1:0]  cnt_init;
    logic [MANT_W+1:0] add_sum;
    logic              add_sgn;
    logic [MANT_W+1:0] norm_sum;
    logic [EXP_W-1:0]  norm_exp;

    assign dbg_state = state;

    dec_operanzi u_dec (
        .a        (ra),
        .b        (rb),
        .swap     (swap),
        .exp_max  (exp_max),
        .exp_diff (exp_diff),
        .op_class (op_class)
    );

    always_comb begin
        cnt_init = CNT_W'(exp_diff);
        if (int'(exp_diff) >= MAX_SHIFT)
            cnt_init = CNT_W'(MAX_SHIFT);
    end

    // Signed-magnitude add; the larger magnitude sets the sign.
    always_comb begin
        add_sum = '0;
        add_sgn = sx;
        if (sx == sy) begin
            add_sum = {1'b0, mx} + {1'b0, my};
        end else if (mx >= my) begin
            add_sum = {1'b0, mx} - {1'b0, my};
        end else begin
            add_sum = {1'b0, my} - {1'b0, mx};
            add_sgn = sy;
        end
    end

    // One normalization step. The post-shift value is checked in the same
    // cycle, so the last shift also writes the result.
    always_comb begin
        norm_sum = sum << 1;
        norm_exp = exp_r - 8'd1;
        if (sum[MANT_W+1]) begin
            norm_sum = sum >> 1;
            norm_exp = exp_r + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            nan       <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            cnt       <= '0;
            mx        <= '0;
            my        <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            exp_r     <= '0;
            sum       <= '0;
            sgn       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra       <= a;
                        rb       <= b;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end

                CMP: begin
                    case (op_class)
                        CLS_NAN: begin
                            result    <= QNAN;
                            nan       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                        CLS_INF: begin
                            result    <= (ra[30:23] == EXP_INF) ? ra : rb;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                        CLS_ZERO: begin
                            if (ra[30:23] == '0 && rb[30:23] == '0)
                                result <= {ra[31] & rb[31], 31'b0};
                            else if (ra[30:23] == '0)
                                result <= rb;
                            else
                                result <= ra;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                        default: begin
                            mx    <= swap ? {1'b1, rb[MANT_W-1:0]} : {1'b1, ra[MANT_W-1:0]};
                            my    <= swap ? {1'b1, ra[MANT_W-1:0]} : {1'b1, rb[MANT_W-1:0]};
                            sx    <= swap ? rb[31] : ra[31];
                            sy    <= swap ? ra[31] : rb[31];
                            exp_r <= exp_max;
                            cnt   <= cnt_init;
                            state <= (cnt_init != '0) ? ALIGN : ADD;
                        end
                    endcase
                end

                ALIGN: begin
                    my  <= my >> 1;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= ADD;
                end

                ADD: begin
                    if (add_sum == '0) begin
                        result    <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (add_sum[MANT_W+1:MANT_W] == 2'b01) begin
                        // Already normalized: no NORM cycle needed.
                        result    <= {add_sgn, exp_r, add_sum[MANT_W-1:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sum   <= add_sum;
                        sgn   <= add_sgn;
                        state <= NORM;
                    end
                end

                NORM: begin
                    if (sum[MANT_W+1] && norm_exp == EXP_INF) begin
                        result    <= {sgn, EXP_INF, 23'b0};
                        ovf       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (!sum[MANT_W+1] && norm_exp == '0) begin
                        result    <= {sgn, 31'b0};
                        unf       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (norm_sum[MANT_W+1:MANT_W] == 2'b01) begin
                        result    <= {sgn, norm_exp, norm_sum[MANT_W-1:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sum   <= norm_sum;
                        exp_r <= norm_exp;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
                        nan       <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_adunare.sv
// tb_ctrl_adunare: directed and randomized checks of ctrl_adunare against a
// behavioural model of the floating-point add rules and latency formula.
module tb_ctrl_adunare;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        nan;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected entry: {latency[7:0], nan, unf, ovf, result[31:0]}
  logic [42:0] exp_q[$];

  ctrl_adunare #(.MAX_SHIFT(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .nan       (nan),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [42:0] pack_exp(input int lat, input logic fn, input logic fu,
                                           input logic fo, input logic [31:0] r);
    return {8'(lat), fn, fu, fo, r};
  endfunction

  // ---------------- reference model ----------------
  // Arithmetic view: signed integer add of the aligned significands, then
  // normalize one bit at a time counting shifts for the latency.
  function automatic logic [42:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    int ea, eb, ma, mb, hi_m, lo_m, d, sh, s, mag, e, lat;
    logic sa, sb, hi_s, lo_s, sgn, fn, fu, fo, fin;
    logic [31:0] res, magv;
    ea = int'(x[30:23]); eb = int'(y[30:23]);
    ma = int'(x[22:0]);  mb = int'(y[22:0]);
    sa = x[31]; sb = y[31];
    fn = 1'b0; fu = 1'b0; fo = 1'b0; res = 32'h0; lat = 2;
    if (ea == 255 || eb == 255) begin
      if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) || (ea == 255 && eb == 255 && sa != sb)) begin
        res = 32'h7FC00000;
        fn  = 1'b1;
      end else begin
        res = (ea == 255) ? x : y;
      end
    end else if (ea == 0 || eb == 0) begin
      if (ea == 0 && eb == 0) res = {sa & sb, 31'b0};
      else                    res = (ea == 0) ? y : x;
    end else begin
      if (eb > ea) begin
        hi_m = mb + (1 << 23); hi_s = sb; lo_m = ma + (1 << 23); lo_s = sa; e = eb; d = eb - ea;
      end else begin
        hi_m = ma + (1 << 23); hi_s = sa; lo_m = mb + (1 << 23); lo_s = sb; e = ea; d = ea - eb;
      end
      sh   = (d < 25) ? d : 25;
      lo_m = lo_m >> sh;
      s    = (hi_s ? -hi_m : hi_m) + (lo_s ? -lo_m : lo_m);
      sgn  = (s < 0);
      mag  = sgn ? -s : s;
      lat  = 3 + sh;
      if (mag != 0) begin
        fin = 1'b0;
        while (!fin) begin
          if (mag >= (1 << 24)) begin
            mag = mag >> 1; e++; lat++;
            if (e == 255) begin res = {sgn, 8'hFF, 23'b0}; fo = 1'b1; fin = 1'b1; end
          end else if (mag < (1 << 23)) begin
            mag = mag << 1; e--; lat++;
            if (e == 0) begin res = {sgn, 31'b0}; fu = 1'b1; fin = 1'b1; end
          end else begin
            magv = 32'(mag);
            res  = {sgn, 8'(e), magv[22:0]};
            fin  = 1'b1;
          end
        end
      end
    end
    return pack_exp(lat, fn, fu, fo, res);
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_, input logic [42:0] expv,
                         input int hold);
    int lat;
    logic [42:0] e;
    logic [31:0] held_r;
    logic [2:0]  held_f;
    exp_q.push_back(expv);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Keep in_valid high with junk operands while busy; it must be ignored.
    a = $urandom; b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    e = exp_q.pop_front();
    check("result", 64'(result), 64'(e[31:0]));
    check("ovf", 64'(ovf), 64'(e[32]));
    check("unf", 64'(unf), 64'(e[33]));
    check("nan", 64'(nan), 64'(e[34]));
    check("latency", 64'(lat), 64'(e[42:35]));
    check("in_ready_busy", 64'(in_ready), 64'd0);
    held_r = result;
    held_f = {nan, unf, ovf};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'(held_r));
      check("hold_flags", 64'({nan, unf, ovf}), 64'(held_f));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_flags", 64'({nan, unf, ovf}), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] x, y, t;
    int sel, e0, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({nan, unf, ovf}), 64'd0);
    rst = 1'b0;

    // Directed cases with hand-derived results and latencies.
    run_txn(32'h3F800000, 32'h3F800000, pack_exp(4, 0, 0, 0, 32'h40000000), 0);
    run_txn(32'h3FC00000, 32'hBFA00000, pack_exp(5, 0, 0, 0, 32'h3E800000), 0);
    run_txn(32'h3F800000, 32'h30800000, pack_exp(28, 0, 0, 0, 32'h3F800000), 0);
    run_txn(32'h3F800000, 32'hBF800000, pack_exp(3, 0, 0, 0, 32'h00000000), 0);
    run_txn(32'h7F7FFFFF, 32'h7F7FFFFF, pack_exp(4, 0, 0, 1, 32'h7F800000), 0);
    run_txn(32'h7FC00001, 32'h3F800000, pack_exp(2, 1, 0, 0, 32'h7FC00000), 10);
    run_txn(32'h00C00000, 32'h80A00000, pack_exp(4, 0, 1, 0, 32'h00000000), 0);
    run_txn(32'h7F800000, 32'hFF800000, pack_exp(2, 1, 0, 0, 32'h7FC00000), 0);
    run_txn(32'hFF800000, 32'h3F800000, pack_exp(2, 0, 0, 0, 32'hFF800000), 0);
    run_txn(32'h80000000, 32'h80000000, pack_exp(2, 0, 0, 0, 32'h80000000), 0);
    run_txn(32'h00000000, 32'hC0490FDB, pack_exp(2, 0, 0, 0, 32'hC0490FDB), 0);

    // Reset in the middle of ALIGN aborts the transaction.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h30800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_align_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_emit", 64'(seen), 64'd0);

    // Randomized operand pairs checked against the model.
    for (int n = 0; n < 300; n++) begin
      x = $urandom; y = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        1: begin x[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) x[22:0] = '0; end
        2: y[30:23] = 8'h00;
        3, 4, 5: begin
          e0 = $urandom_range(3, 250);
          x[30:23] = 8'(e0);
          y[30:23] = 8'(e0 - 2 + $urandom_range(0, 4));
        end
        6: begin
          e0 = $urandom_range(40, 250);
          x[30:23] = 8'(e0);
          y[30:23] = 8'(e0 - $urandom_range(0, 30));
        end
        7: begin
          x[30:23] = 8'($urandom_range(250, 254));
          y[30:23] = x[30:23]; y[31] = x[31];
        end
        8: begin
          x[30:23] = 8'($urandom_range(1, 3));
          y[30:23] = x[30:23]; y[31] = ~x[31];
        end
        9: begin
          y = x ^ 32'h80000000;
          y[3:0] = 4'($urandom);
        end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin t = x; x = y; y = t; end
      run_txn(x, y, ref_add(x, y), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
